// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a data-memory range and streams each word LSB-first as bytes over valid/ready.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum trailer byte after the data bytes.
module mem_dump_reader #(
  parameter int NB_BITS  = 32,
  parameter int NB_DEPTH = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_DEPTH-1:0] i_base,
  input  logic [NB_DEPTH:0]   i_n_words,
  output logic [NB_DEPTH-1:0] o_mem_addr,
  output logic                o_mem_re,
  input  logic [NB_BITS-1:0]  i_mem_data,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);
`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, CHK, DONE} state_t;
  localparam state_t LAST = CHK;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  localparam state_t LAST = DONE;
`endif
  localparam logic [NB_DEPTH:0]   ONE_WORD = 1;
  localparam logic [NB_DEPTH-1:0] ONE_ADDR = 1;
  state_t              state_q;
  logic [NB_DEPTH-1:0] addr_q;
  logic [NB_DEPTH:0]   left_q;
  logic [NB_DEPTH:0]   n_words_d;
  logic [NB_BITS-1:0]  word_q;
  logic [1:0]          idx_q;
  logic [7:0]          byte_d;
  assign n_words_d  = i_n_words[NB_DEPTH] ? {1'b1, {NB_DEPTH{1'b0}}} : i_n_words;
  assign byte_d     = word_q[{idx_q, 3'b000} +: 8];
  assign o_mem_addr = addr_q;
  assign o_mem_re   = state_q == READ;
  assign o_busy     = state_q != IDLE;
  assign o_done     = state_q == DONE;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum_q;
  assign o_tx_data  = state_q == CHK ? csum_q : byte_d;
  assign o_tx_valid = state_q == SEND || state_q == CHK;
`else
  assign o_tx_data  = byte_d;
  assign o_tx_valid = state_q == SEND;
`endif
  // Abort wins over every transition, even a handshake in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else if (i_abort && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          addr_q  <= i_base;
          left_q  <= n_words_d;
          state_q <= n_words_d == '0 ? LAST : READ;
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end
        READ: state_q <= WAIT;
        WAIT: begin
          word_q  <= i_mem_data;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: if (i_tx_ready) begin
          idx_q <= idx_q + 2'd1;
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_q <= csum_q ^ byte_d;
`endif
          if (idx_q == 2'd3) begin
            left_q  <= left_q - ONE_WORD;
            addr_q  <= addr_q + ONE_ADDR;
            state_q <= left_q == ONE_WORD ? LAST : READ;
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        CHK: if (i_tx_ready) state_q <= DONE;
`endif
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Debug-path reader for the MIPS data memory: on a start pulse it walks a range of data-memory words, reads each through the memory's synchronous read port and streams every word out as four bytes over a valid/ready byte interface toward the debug UART transmitter. It sits beside the MEM stage on the data-memory read port, which the debug unit muxes to it while the pipeline is halted, and is the read-out counterpart of the pipeline's store path.

## Interface
- `NB_BITS`, 32: data-memory word width; must be 32, because each word is sent as 4 bytes.
- `NB_DEPTH`, 10: data-memory word-address width.
- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-low.
- `i_start`, input, 1: start request; sampled only in IDLE.
- `i_abort`, input, 1: cancels any dump in progress.
- `i_base`, input, `NB_DEPTH`: first word index, latched on start.
- `i_n_words`, input, `NB_DEPTH+1`: number of words, latched on start.
- `o_mem_addr`, output, `NB_DEPTH`: word address to the data memory.
- `o_mem_re`, output, 1: read enable; data is valid on `i_mem_data` in the following cycle.
- `i_mem_data`, input, `NB_BITS`: synchronous read data.
- `o_tx_data`, output, 8: byte to the transmitter.
- `o_tx_valid`, output, 1: `o_tx_data` is valid.
- `i_tx_ready`, input, 1: the transmitter accepts the byte this cycle.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_done`, output, 1: one-cycle pulse when a dump completes.

## Operation
- States: IDLE, READ, WAIT, SEND, CHK (CHK exists only when the checksum feature is compiled in), DONE.
- IDLE:
  - With `i_start` high and `i_n_words` = 0, go to DONE.
  - With `i_start` high and `i_n_words` nonzero, latch the inputs and go to READ.
  - Values of `i_n_words` above 2^`NB_DEPTH` are clamped to 2^`NB_DEPTH`.
- READ: `o_mem_re` = 1 with `o_mem_addr` = current address; go to WAIT.
- WAIT: capture `i_mem_data` into the word register and set the byte index to 0; go to SEND.
- SEND:
  - `o_tx_valid` = 1, `o_tx_data` = byte[index], least-significant byte first (bits 7:0 first, then 15:8, 23:16, 31:24).
  - A transfer occurs when `o_tx_valid` and `i_tx_ready` are both high; the index then increments.
  - After byte 3 transfers:
    - If words remain, increment the address and go to READ.
    - Otherwise go to CHK if the checksum feature is enabled, else go to DONE.
- CHK: send the checksum byte under the same handshake, then go to DONE.
- DONE: `o_done` = 1 for one cycle; go to IDLE.
- Address arithmetic is modulo 2^`NB_DEPTH`: address 2^`NB_DEPTH`−1 wraps to 0.
- `i_start` outside IDLE is ignored.
- `i_abort` in any non-IDLE state: go to IDLE on the next edge. `o_tx_valid` drops, `o_done` is not pulsed, and any partially sent word is discarded. `i_abort` has priority over every other transition, including a handshake in the same cycle; that byte counts as sent, but the dump still ends.
- `i_abort` has no effect in IDLE. When `i_abort` and `i_start` are high together in IDLE, the start is taken.
- Handshake rules:
  - Once raised, `o_tx_valid` stays high and `o_tx_data` stays stable until the transfer completes (abort and reset are the only exceptions).
  - `o_tx_valid` never depends combinationally on `i_tx_ready`.

## Timing
- Reset values: `o_mem_addr` = 0, `o_mem_re` = 0, `o_tx_data` = 0, `o_tx_valid` = 0, `o_busy` = 0, `o_done` = 0. State goes to IDLE and all counters clear.
- Reset takes effect immediately when `i_rst` falls, with no clock edge needed, including in the middle of a dump.
- With start sampled at edge T:
  - READ occupies cycle T+1 (`o_mem_re` high).
  - WAIT occupies T+2.
  - The first byte is valid at T+3.
- With `i_tx_ready` held high:
  - Each word takes 6 cycles (READ, WAIT, 4×SEND).
  - An N-word dump without checksum pulses `o_done` at cycle T+1+6N.
  - With checksum, the pulse comes one cycle later.
- Each cycle `i_tx_ready` is low during SEND or CHK adds one cycle.
- `o_mem_re` is high for exactly one cycle per word.

## Configuration
- Macro: `MEM_DUMP_CHECKSUM_EN`.
- Defined:
  - The CHK state exists.
  - After the last data byte, one trailer byte is sent, equal to the XOR of every data byte sent in this dump.
  - The checksum register clears on start.
  - A dump with `i_n_words` = 0 sends the single byte 0x00 before DONE.
- Not defined:
  - No trailer byte and no CHK state.
  - A dump with `i_n_words` = 0 sends nothing.

## Test plan
- Two-word dump, no stall:
  - Stimulus: memory[0] = 0x11223344, memory[1] = 0xAABBCCDD; start with `i_base` = 0, `i_n_words` = 2, `i_tx_ready` = 1.
  - Required: bytes 44 33 22 11 DD CC BB AA.
  - `o_done` at T+13; with `MEM_DUMP_CHECKSUM_EN`, trailer byte 0x44 and `o_done` at T+14.
- Backpressure:
  - Stimulus: hold `i_tx_ready` low for 5 cycles while byte 0x33 is valid, and pulse `i_start` during the stall.
  - Required: `o_tx_data` stays 0x33 with `o_tx_valid` high, no byte is lost or duplicated, and the start pulse is ignored.
- Zero words:
  - Stimulus: start with `i_n_words` = 0.
  - Required: `o_mem_re` never rises and `o_done` is at T+1.
  - With checksum: byte 0x00, then `o_done`.
- Address wrap:
  - Stimulus: `i_base` = 1023, `i_n_words` = 2.
  - Required: `o_mem_addr` is 1023, then 0 on successive READ cycles.
- Abort:
  - Stimulus: `i_abort` during the second SEND byte.
  - Required: next cycle `o_tx_valid` = 0, `o_busy` = 0 and no `o_done` pulse; a following start with `i_base` = 0, `i_n_words` = 1 dumps correctly.
- Asynchronous reset:
  - Stimulus: drop `i_rst` mid-WAIT, between clock edges.
  - Required: all outputs go to their reset values before the next edge, and the block restarts cleanly after `i_rst` rises.
